// File: rtl/onehot_sel_guard.sv
// Hardened one-hot select decode with glitch checker and sticky error flags.
// Optional strict check (dropped / out-of-range hot bit) under ONEHOT_SEL_GUARD_STRICT_EN.
module onehot_sel_guard_buf #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] f,
  output logic [W-1:0] y
);
  assign y = a ^ f;
endmodule

module onehot_sel_guard #(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 2 ** AddrWidth,
  parameter bit AddrCheck   = 1'b1,
  parameter bit EnableCheck = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  input  logic [OneHotWidth-1:0] fault_i,
  input  logic                   clr_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic                   err_o,
  output logic                   err_q_o,
  output logic [3:0]             cause_q_o
);
  localparam int P = 1 << AddrWidth;

  if (AddrCheck && !EnableCheck) begin : g_bad_cfg
    $error("AddrCheck=1 requires EnableCheck=1");
  end
  if (OneHotWidth < 2 || OneHotWidth > P) begin : g_bad_width
    $error("OneHotWidth out of range 2..2**AddrWidth");
  end

  logic [OneHotWidth-1:0] dec;
  logic [OneHotWidth-1:0] oh_raw;
  logic [OneHotWidth-1:0] oh_buf;
  logic [P-1:0]           oh_pad;

  always_comb begin
    dec = '0;
    for (int i = 0; i < OneHotWidth; i++) begin
      dec[i] = (addr_i == AddrWidth'(i));
    end
  end

  assign oh_raw = dec & {OneHotWidth{en_i}};

  (* keep = "true", dont_touch = "true" *)
  onehot_sel_guard_buf #(
    .W (OneHotWidth)
  ) u_buf (
    .a (oh_raw),
    .f (fault_i),
    .y (oh_buf)
  );

  assign oh_o = oh_buf;

  always_comb begin
    oh_pad = '0;
    oh_pad[OneHotWidth-1:0] = oh_buf;
  end

  // pairwise tree: any = some bit hot, mul = two or more hot
  for (genvar l = 0; l <= AddrWidth; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [N-1:0] any;
    logic [N-1:0] mul;
    if (l == 0) begin : g_leaf
      assign any = oh_pad;
      assign mul = '0;
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_n
        assign any[j] = g_lvl[l-1].any[2*j]
                      | g_lvl[l-1].any[2*j+1];
        assign mul[j] = g_lvl[l-1].mul[2*j]
                      | g_lvl[l-1].mul[2*j+1]
                      | (g_lvl[l-1].any[2*j]
                         & g_lvl[l-1].any[2*j+1]);
      end
    end
  end

  logic onehot_err, enable_err, addr_err, strict_err;
  logic [3:0] cause, cause_q;

  assign onehot_err = g_lvl[AddrWidth].mul[0];
  assign enable_err = EnableCheck & ~en_i
                    & g_lvl[AddrWidth].any[0];
  assign addr_err   = AddrCheck & en_i
                    & (|(oh_buf & ~dec));
`ifdef ONEHOT_SEL_GUARD_STRICT_EN
  assign strict_err = en_i & ~(|(oh_buf & dec));
`else
  assign strict_err = 1'b0;
`endif

  // cause bit order: {strict, enable, addr, onehot}
  assign cause = {strict_err, enable_err, addr_err, onehot_err};
  assign err_o = |cause;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q <= '0;
    end else begin
      cause_q <= (cause_q & ~{4{clr_i}}) | cause;
    end
  end

  assign cause_q_o = cause_q;
  assign err_q_o   = |cause_q;
endmodule

// File: tb/tb_onehot_sel_guard.sv
// Self-checking bench for onehot_sel_guard: directed scenarios plus
// randomized traffic against a set-arithmetic reference model.
module tb_onehot_sel_guard;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  addr_i = '0;
  logic        en_i = 1'b0;
  logic [31:0] fault_i = '0;
  logic        clr_i = 1'b0;
  logic [31:0] oh_o;
  logic        err_o, err_q_o;
  logic [3:0]  cause_q_o;

  logic [1:0]  addr3 = '0;
  logic        en3 = 1'b0;
  logic [2:0]  fault3 = '0;
  logic [2:0]  oh3;
  logic        err3, err_q3;
  logic [3:0]  cause_q3;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_q = '0;

  always #5 clk_i = ~clk_i;

  onehot_sel_guard dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .en_i      (en_i),
    .fault_i   (fault_i),
    .clr_i     (clr_i),
    .oh_o      (oh_o),
    .err_o     (err_o),
    .err_q_o   (err_q_o),
    .cause_q_o (cause_q_o)
  );

  onehot_sel_guard #(
    .AddrWidth   (2),
    .OneHotWidth (3)
  ) dut3 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr3),
    .en_i      (en3),
    .fault_i   (fault3),
    .clr_i     (1'b0),
    .oh_o      (oh3),
    .err_o     (err3),
    .err_q_o   (err_q3),
    .cause_q_o (cause_q3)
  );

  function automatic logic [31:0] m_oh(logic en, logic [4:0] a,
                                       logic [31:0] f);
    logic [31:0] r;
    r = en ? (32'd1 << a) : 32'd0;
    return r ^ f;
  endfunction

  function automatic logic [3:0] m_cause(logic en, logic [4:0] a,
                                         logic [31:0] f);
    logic [31:0] v;
    logic oe, ee, ae, se;
    v  = m_oh(en, a, f);
    oe = $countones(v) > 1;
    ee = !en && (v != 0);
    ae = en && ((v & ~(32'd1 << a)) != 0);
`ifdef ONEHOT_SEL_GUARD_STRICT_EN
    se = en && !v[a];
`else
    se = 1'b0;
`endif
    return {se, ee, ae, oe};
  endfunction

  task automatic tick();
    logic [3:0] nxt;
    nxt = rst_i ? 4'd0
        : ((m_q & ~{4{clr_i}}) | m_cause(en_i, addr_i, fault_i));
    @(posedge clk_i);
    #1;
    m_q = nxt;
  endtask

  task automatic set_in(logic en, logic [4:0] a, logic [31:0] f,
                        logic clr);
    en_i = en; addr_i = a; fault_i = f; clr_i = clr;
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b0);
    rst_i = 1'b1;
    tick(); tick();
    checks++;
    if (cause_q_o !== 4'd0 || err_q_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cause_q=%b err_q=%b want 0000/0",
               cause_q_o, err_q_o);
    end
    set_in(1'b0, 5'd0, 32'h4, 1'b0);
    checks++;
    if (err_o !== 1'b1 || oh_o !== 32'h4) begin
      errors++;
      $display("FAIL reset_comb err=%b oh=%h want 1/4", err_o, oh_o);
    end
    tick();
    checks++;
    if (cause_q_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold cause_q=%b want 0000", cause_q_o);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b1, 5'(a), 32'd0, 1'b0);
      checks++;
      if (oh_o !== (32'd1 << a) || err_o !== 1'b0) begin
        errors++;
        $display("FAIL sweep[%0d] oh=%h err=%b want %h/0",
                 a, oh_o, err_o, 32'd1 << a);
      end
      tick();
      checks++;
      if (err_q_o !== 1'b0) begin
        errors++;
        $display("FAIL sweep_q[%0d] err_q=%b want 0", a, err_q_o);
      end
    end
  endtask

  task automatic test_extra_bit();
    set_in(1'b1, 5'd3, 32'h100, 1'b0);
    checks++;
    if (oh_o !== 32'h108 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL extra_bit oh=%h err=%b want 108/1", oh_o, err_o);
    end
    tick();
    checks++;
    if (err_q_o !== 1'b1 || cause_q_o !== 4'b0011) begin
      errors++;
      $display("FAIL extra_bit_q err_q=%b cause=%b want 1/0011",
               err_q_o, cause_q_o);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_enable();
    set_in(1'b0, 5'd0, 32'h4, 1'b0);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL enable err=%b want 1", err_o);
    end
    tick();
    checks++;
    if (cause_q_o !== 4'b0100) begin
      errors++;
      $display("FAIL enable_q cause=%b want 0100", cause_q_o);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    checks++;
    if (cause_q_o !== 4'b0000 || err_q_o !== 1'b0) begin
      errors++;
      $display("FAIL enable_clr cause=%b err_q=%b want 0000/0",
               cause_q_o, err_q_o);
    end
    clr_i = 1'b0;
  endtask

  task automatic test_drop();
    set_in(1'b1, 5'd5, 32'h20, 1'b0);
`ifdef ONEHOT_SEL_GUARD_STRICT_EN
    checks++;
    if (err_o !== 1'b1 || oh_o !== 32'd0) begin
      errors++;
      $display("FAIL drop err=%b oh=%h want 1/0", err_o, oh_o);
    end
    tick();
    checks++;
    if (cause_q_o !== 4'b1000) begin
      errors++;
      $display("FAIL drop_q cause=%b want 1000", cause_q_o);
    end
`else
    checks++;
    if (err_o !== 1'b0 || oh_o !== 32'd0) begin
      errors++;
      $display("FAIL drop err=%b oh=%h want 0/0", err_o, oh_o);
    end
    tick();
    checks++;
    if (cause_q_o !== 4'b0000) begin
      errors++;
      $display("FAIL drop_q cause=%b want 0000", cause_q_o);
    end
`endif
    set_in(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_clr_vs_new();
    set_in(1'b0, 5'd0, 32'h1, 1'b0);
    tick();
    set_in(1'b1, 5'd2, 32'h3, 1'b1);
    tick();
    checks++;
    if (cause_q_o !== 4'b0011) begin
      errors++;
      $display("FAIL clr_vs_new cause=%b want 0011", cause_q_o);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset_priority();
    set_in(1'b0, 5'd0, 32'h80, 1'b0);
    tick();
    checks++;
    if (err_q_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre err_q=%b want 1", err_q_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (err_q_o !== 1'b0 || cause_q_o !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid err_q=%b cause=%b want 0/0000",
               err_q_o, cause_q_o);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if (err_q_o !== 1'b1 || cause_q_o !== 4'b0100) begin
      errors++;
      $display("FAIL rst_post err_q=%b cause=%b want 1/0100",
               err_q_o, cause_q_o);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_narrow();
    for (int a = 0; a < 3; a++) begin
      en3 = 1'b1; addr3 = 2'(a); fault3 = '0;
      #1;
      checks++;
      if (oh3 !== (3'd1 << a) || err3 !== 1'b0) begin
        errors++;
        $display("FAIL narrow[%0d] oh=%b err=%b", a, oh3, err3);
      end
    end
    addr3 = 2'd3;
    #1;
    checks++;
`ifdef ONEHOT_SEL_GUARD_STRICT_EN
    if (oh3 !== 3'd0 || err3 !== 1'b1) begin
      errors++;
      $display("FAIL narrow_oor oh=%b err=%b want 000/1", oh3, err3);
    end
`else
    if (oh3 !== 3'd0 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL narrow_oor oh=%b err=%b want 000/0", oh3, err3);
    end
`endif
    en3 = 1'b0; fault3 = 3'b110;
    #1;
    checks++;
    if (err3 !== 1'b1) begin
      errors++;
      $display("FAIL narrow_multi err=%b want 1", err3);
    end
    fault3 = '0;
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] f;
    logic [31:0] eo;
    logic [3:0]  ec;
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: f = 32'd0;
        1: f = 32'd1 << $urandom_range(0, 31);
        2: f = 32'd1 << a;
        default: f = $urandom;
      endcase
      rst_i = ($urandom_range(0, 15) == 0);
      set_in(1'($urandom_range(0, 1)), a, f,
             ($urandom_range(0, 3) == 0));
      eo = m_oh(en_i, addr_i, fault_i);
      ec = m_cause(en_i, addr_i, fault_i);
      checks++;
      if (oh_o !== eo || err_o !== (|ec)) begin
        errors++;
        $display("FAIL rand_comb[%0d] oh=%h err=%b want %h/%b",
                 n, oh_o, err_o, eo, |ec);
      end
      tick();
      checks++;
      if (cause_q_o !== m_q || err_q_o !== (|m_q)) begin
        errors++;
        $display("FAIL rand_q[%0d] cause=%b err_q=%b want %b/%b",
                 n, cause_q_o, err_q_o, m_q, |m_q);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_extra_bit();
    test_enable();
    test_drop();
    test_clr_vs_new();
    test_reset_priority();
    test_narrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
